// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Read hits are returned combinationally in the access cycle. A miss fill or a
// write-through holds stall high until the backing memory acknowledges; a single
// RESP cycle then hands the result to the pipeline with stall low.
// Backing-memory handshake: bm_req is held high with bm_we/bm_addr/bm_wdata stable
// until a one-cycle bm_ack pulse completes the transfer; bm_rdata is valid only in
// the cycle bm_ack is 1, and bm_req drops in the following cycle.
module data_cache_ctrl #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        bm_req,
    output logic        bm_we,
    output logic [31:0] bm_addr,
    output logic [31:0] bm_wdata,
    input  logic [31:0] bm_rdata,
    input  logic        bm_ack
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state;
    logic [LINES-1:0]        valid;
    logic [TAG_BITS-1:0]     tag_array  [LINES];
    logic [31:0]             data_array [LINES];
    logic [31:0]             resp_data;

    logic [INDEX_BITS-1:0]   index;
    logic [TAG_BITS-1:0]     tag;
    logic                    hit;
    logic                    unused_byte_sel;

    // Address split; the byte offset does not select anything in a word cache.
    always_comb begin
        index           = addr[INDEX_BITS+1:2];
        tag             = addr[31:INDEX_BITS+2];
        hit             = valid[index] && (tag_array[index] == tag);
        unused_byte_sel = ^addr[1:0];
    end

    // Stall and load data depend only on state, requests and hit, never on bm_ack.
    always_comb begin
        stall = 1'b0;
        rdata = 32'h0;
        case (state)
            IDLE: begin
                if (mem_write) begin
                    stall = 1'b1;
                end else if (mem_read) begin
                    stall = !hit;
                    rdata = hit ? data_array[index] : 32'h0;
                end
            end
            FILL, WRITE: stall = 1'b1;
            RESP:        rdata = resp_data;
            default:     stall = 1'b0;
        endcase
    end

    // Control FSM with registered backing-memory request and valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            bm_req    <= 1'b0;
            bm_we     <= 1'b0;
            bm_addr   <= 32'h0;
            bm_wdata  <= 32'h0;
            resp_data <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_write) begin
                        state    <= WRITE;
                        bm_req   <= 1'b1;
                        bm_we    <= 1'b1;
                        bm_addr  <= {addr[31:2], 2'b00};
                        bm_wdata <= wdata;
                    end else if (mem_read && !hit) begin
                        state   <= FILL;
                        bm_req  <= 1'b1;
                        bm_we   <= 1'b0;
                        bm_addr <= {addr[31:2], 2'b00};
                    end
                end
                FILL: begin
                    if (bm_ack) begin
                        valid[index] <= 1'b1;
                        resp_data    <= bm_rdata;
                        bm_req       <= 1'b0;
                        state        <= RESP;
                    end
                end
                WRITE: begin
                    if (bm_ack) begin
                        resp_data <= 32'h0;
                        bm_req    <= 1'b0;
                        bm_we     <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays: filled on a read miss, updated by a write that hits.
    always_ff @(posedge clk) begin
        if (state == FILL && bm_ack) begin
            tag_array[index]  <= tag;
            data_array[index] <= bm_rdata;
        end else if (state == WRITE && bm_ack && hit) begin
            data_array[index] <= wdata;
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: directed accesses against a responding memory model.
// The driver pushes expected load data and expected backing-memory transactions
// into queues; independent monitors pop and compare when the DUT presents them.
module tb_data_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] rdata;
  logic        stall;
  logic        bm_req;
  logic        bm_we;
  logic [31:0] bm_addr;
  logic [31:0] bm_wdata;
  logic [31:0] bm_rdata;
  logic        bm_ack;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [64:0] bm_exp_q[$];
  logic        bm_req_prev = 1'b0;

  data_cache_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .rdata     (rdata),
    .stall     (stall),
    .bm_req    (bm_req),
    .bm_we     (bm_we),
    .bm_addr   (bm_addr),
    .bm_wdata  (bm_wdata),
    .bm_rdata  (bm_rdata),
    .bm_ack    (bm_ack)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // load-data monitor: a completed access is a held request with stall low
  always @(negedge clk) begin
    if (!reset && (mem_read || mem_write) && !stall) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdata_unexpected: got %h expected no completion", rdata);
      end else begin
        check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  // backing-memory monitor: each new request is compared with the expected one
  always @(negedge clk) begin
    logic [64:0] e;
    if (!reset && bm_req && !bm_req_prev) begin
      if (bm_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bm_unexpected: got req addr %h expected no request", bm_addr);
      end else begin
        e = bm_exp_q.pop_front();
        check("bm_we", {31'h0, bm_we}, {31'h0, e[64]});
        check("bm_addr", bm_addr, e[63:32]);
        if (e[64]) check("bm_wdata", bm_wdata, e[31:0]);
      end
    end
    bm_req_prev <= bm_req;
  end

  // inputs must not change while stall is high
  logic        snap_valid = 1'b0;
  logic [65:0] snap;
  always @(negedge clk) begin
    if (snap_valid && !reset) begin
      check("input_stable", {30'h0, snap[65:64]}, {30'h0, mem_write, mem_read});
      check("input_stable_addr", addr, snap[63:32]);
    end
    snap_valid = stall && !reset;
    snap = {mem_write, mem_read, addr, wdata};
  end

  // driver: one access, responds to the backing request after ack_dly cycles
  task automatic access(input logic we, input logic rd, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_dly, input logic [31:0] fill,
                        input logic [31:0] exp_rdata, input logic exp_bm,
                        input int exp_cycles);
    int cycles = 0;
    int waited = 0;
    bit done = 0;
    exp_q.push_back(exp_rdata);
    if (exp_bm) bm_exp_q.push_back({we, a & 32'hFFFF_FFFC, wd});
    mem_write = we; mem_read = rd; addr = a; wdata = wd;
    while (!done) begin
      @(negedge clk);
      cycles++;
      if (!stall) begin
        done = 1;
      end else if (bm_req) begin
        if (waited == ack_dly) begin
          bm_ack = 1'b1;
          bm_rdata = fill;
        end
        waited++;
      end
      if (!done && cycles > 60) begin
        checks++; errors++;
        $display("FAIL timeout: got no completion at %h expected one within 60 cycles", a);
        done = 1;
      end
      @(posedge clk);
      #1;
      bm_ack = 1'b0;
      bm_rdata = 32'h0;
    end
    check("latency", cycles, exp_cycles);
    mem_write = 1'b0; mem_read = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; addr = 32'h0; wdata = 32'h0; mem_write = 1'b0; mem_read = 1'b0;
    bm_rdata = 32'h0; bm_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_bm_req", {31'h0, bm_req}, 32'h0);
    check("rst_bm_we", {31'h0, bm_we}, 32'h0);
    check("rst_bm_addr", bm_addr, 32'h0);
    check("rst_bm_wdata", bm_wdata, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // cold miss, ack after 3 cycles
    access(0, 1, 32'h100, 32'h0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1, 6);
    // hit: zero latency, no backing request
    access(0, 1, 32'h100, 32'h0, 0, 32'h0, 32'hDEADBEEF, 0, 1);
    // same index, new tag: conflict miss, then original line evicted
    access(0, 1, 32'h140, 32'h0, 1, 32'h12345678, 32'h12345678, 1, 4);
    access(0, 1, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 3);
    access(0, 1, 32'h140, 32'h0, 0, 32'h12345678, 32'h12345678, 1, 3);
    // write hit updates the line
    access(1, 0, 32'h140, 32'hCAFEF00D, 2, 32'h0, 32'h0, 1, 5);
    access(0, 1, 32'h140, 32'h0, 0, 32'h0, 32'hCAFEF00D, 0, 1);
    // write miss does not allocate
    access(1, 0, 32'h200, 32'h11112222, 0, 32'h0, 32'h0, 1, 3);
    access(0, 1, 32'h200, 32'h0, 0, 32'h11112222, 32'h11112222, 1, 3);
    // read and write together: write wins, no fill
    access(1, 1, 32'h106, 32'h77778888, 0, 32'h0, 32'h0, 1, 3);
    access(0, 1, 32'h104, 32'h0, 1, 32'h77778888, 32'h77778888, 1, 4);

    // reset in the middle of a fill
    bm_exp_q.push_back({1'b0, 32'h140, 32'h0});
    mem_read = 1'b1; addr = 32'h140;
    n = 0;
    while (!bm_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("fill_started", {31'h0, bm_req}, 32'h1);
    #2 reset = 1'b1;
    #1 check("reset_drops_req", {31'h0, bm_req}, 32'h0);
    mem_read = 1'b0;
    @(posedge clk);
    @(negedge clk); #2 reset = 1'b0;
    // stale ack while idle must be ignored
    @(posedge clk); #1 bm_ack = 1'b1; bm_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1 bm_ack = 1'b0; bm_rdata = 32'h0;
    check("stale_ack_req", {31'h0, bm_req}, 32'h0);
    check("stale_ack_stall", {31'h0, stall}, 32'h0);
    // valid bits were cleared: this misses again
    access(0, 1, 32'h140, 32'h0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 1, 3);

    repeat (2) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 32'h0);
    check("bm_q_drained", bm_exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
